tm_ret_vc_allocator: RTL and testbench

Return-VC allocator and credit scheduler for a NoC master that issues requests to multiple slaves. It binds each outstanding slave key ({vc, dest}) to one of NUM_VC return VCs, tracks outstanding requests per return VC against NUM_CREDITS, and gates the master's send handshake. It also records the issue order of return VCs so the master's reply path can reorder responses. It sits between the master's send skid buffer and the packetizer, and is driven by the per-VC reply-valid strobes from the depacketizer.

---
 rtl/tm_ret_vc_allocator.sv | 177 +++++++++++++++++
 tb/tb_tm_ret_vc_allocator.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tm_ret_vc_allocator.sv
// Return-VC allocator: binds {vc,dest} keys to return VCs, tracks per-VC credits, records issue order.
// Optional checks: define TM_RET_VC_ALLOC_CHECK_EN to enable the sticky err flag (tied to 0 otherwise).
module tm_ret_vc_allocator #(
  parameter int NUM_VC           = 4,
  parameter int VC_ADDRESS_WIDTH = 2,
  parameter int ADDRESS_WIDTH    = 4,
  parameter int NUM_CREDITS      = 32,
  parameter int ORDER_DEPTH      = 64,
  localparam int CW = $clog2(NUM_CREDITS + 1),
  localparam int KW = ADDRESS_WIDTH + VC_ADDRESS_WIDTH,
  localparam int OW = $clog2(ORDER_DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_valid,
  input  logic [KW-1:0]               req_key,
  input  logic                        noc_ready,
  output logic                        req_grant,
  output logic [VC_ADDRESS_WIDTH-1:0] req_ret_vc,
  input  logic [NUM_VC-1:0]           reply_valid,
  output logic [NUM_VC-1:0]           vc_busy,
  output logic                        ord_valid,
  output logic [VC_ADDRESS_WIDTH-1:0] ord_vc,
  input  logic                        ord_pop,
  output logic                        err
);

  logic [NUM_VC-1:0]           bound_q;
  logic [NUM_VC-1:0]           bound_d;
  logic [KW-1:0]               key_q   [NUM_VC];
  logic [KW-1:0]               key_d   [NUM_VC];
  logic [CW-1:0]               count_q [NUM_VC];
  logic [CW-1:0]               count_d [NUM_VC];

  logic [VC_ADDRESS_WIDTH-1:0] ord_mem_q [ORDER_DEPTH];
  logic [OW:0]                 wr_ptr_q;
  logic [OW:0]                 wr_ptr_d;
  logic [OW:0]                 rd_ptr_q;
  logic [OW:0]                 rd_ptr_d;

  logic                        hit_s;
  logic [VC_ADDRESS_WIDTH-1:0] hit_vc_s;
  logic                        free_s;
  logic [VC_ADDRESS_WIDTH-1:0] free_vc_s;
  logic [VC_ADDRESS_WIDTH-1:0] cand_vc_s;
  logic                        eligible_s;
  logic                        fifo_empty_s;
  logic                        fifo_full_s;
  logic                        grant_s;
  logic                        pop_s;

  assign fifo_empty_s = (wr_ptr_q == rd_ptr_q);
  assign fifo_full_s  = (wr_ptr_q[OW] != rd_ptr_q[OW]) &&
                        (wr_ptr_q[OW-1:0] == rd_ptr_q[OW-1:0]);

  // Key lookup and free-VC search on registered state; descending scan leaves the lowest index.
  always_comb begin
    hit_s     = 1'b0;
    hit_vc_s  = '0;
    free_s    = 1'b0;
    free_vc_s = '0;
    for (int i = NUM_VC - 1; i >= 0; i--) begin
      hit_s     = (bound_q[i] && (key_q[i] == req_key)) ? 1'b1 : hit_s;
      hit_vc_s  = (bound_q[i] && (key_q[i] == req_key)) ? VC_ADDRESS_WIDTH'(i) : hit_vc_s;
      free_s    = (!bound_q[i]) ? 1'b1 : free_s;
      free_vc_s = (!bound_q[i]) ? VC_ADDRESS_WIDTH'(i) : free_vc_s;
    end
  end

  // Candidate selection and send-handshake gating; nothing is accepted while in reset.
  always_comb begin
    cand_vc_s  = hit_s ? hit_vc_s : free_vc_s;
    eligible_s = hit_s ? (count_q[hit_vc_s] < CW'(NUM_CREDITS)) : free_s;
    grant_s    = !rst && req_valid && noc_ready && eligible_s && !fifo_full_s;
    pop_s      = ord_pop && !fifo_empty_s;
  end

  assign req_grant  = grant_s;
  assign req_ret_vc = cand_vc_s;

  // Per-VC credit accounting; a reply on an idle VC is dropped so the count saturates at zero.
  always_comb begin
    for (int i = 0; i < NUM_VC; i++) begin
      count_d[i] = count_q[i]
                 + CW'(grant_s && (cand_vc_s == VC_ADDRESS_WIDTH'(i)))
                 - CW'(reply_valid[i] && (count_q[i] != '0));
      bound_d[i] = (count_d[i] != '0);
      key_d[i]   = (grant_s && (cand_vc_s == VC_ADDRESS_WIDTH'(i))) ? req_key : key_q[i];
    end
  end

  // Binding and credit state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bound_q <= '0;
      for (int i = 0; i < NUM_VC; i++) begin
        key_q[i]   <= '0;
        count_q[i] <= '0;
      end
    end else begin
      bound_q <= bound_d;
      for (int i = 0; i < NUM_VC; i++) begin
        key_q[i]   <= key_d[i];
        count_q[i] <= count_d[i];
      end
    end
  end

  // Order FIFO pointer update; full is judged before any same-cycle pop.
  always_comb begin
    wr_ptr_d = grant_s ? (wr_ptr_q + (OW + 1)'(1)) : wr_ptr_q;
    rd_ptr_d = pop_s   ? (rd_ptr_q + (OW + 1)'(1)) : rd_ptr_q;
  end

  // Order FIFO pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Order FIFO storage; contents are only observed behind ord_valid.
  always_ff @(posedge clk) begin
    if (grant_s) begin
      ord_mem_q[wr_ptr_q[OW-1:0]] <= cand_vc_s;
    end else begin
      ord_mem_q[wr_ptr_q[OW-1:0]] <= ord_mem_q[wr_ptr_q[OW-1:0]];
    end
  end

  assign vc_busy   = bound_q;
  assign ord_valid = !fifo_empty_s;
  assign ord_vc    = fifo_empty_s ? '0 : ord_mem_q[rd_ptr_q[OW-1:0]];

`ifdef TM_RET_VC_ALLOC_CHECK_EN
  logic [NUM_VC-1:0] underflow_s;
  logic              err_event_s;
  logic              err_q;
  logic              err_d;

  // Protocol error detection: reply on an idle VC, pop of an empty FIFO, reply with no order entry.
  always_comb begin
    for (int i = 0; i < NUM_VC; i++) begin
      underflow_s[i] = reply_valid[i] && (count_q[i] == '0);
    end
    err_event_s = (|underflow_s) || (ord_pop && fifo_empty_s) || ((|reply_valid) && fifo_empty_s);
    err_d       = err_q || err_event_s;
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;

`ifndef SYNTHESIS
  // Simulation report for each detected protocol error.
  always @(posedge clk) begin
    if (!rst && (|underflow_s)) $error("tm_ret_vc_allocator: reply on idle VC %b", underflow_s);
    if (!rst && ord_pop && fifo_empty_s) $error("tm_ret_vc_allocator: pop of empty order FIFO");
    if (!rst && (|reply_valid) && fifo_empty_s) $error("tm_ret_vc_allocator: reply with empty order FIFO");
  end
`endif
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_tm_ret_vc_allocator.sv
// Self-checking bench for tm_ret_vc_allocator: directed scenarios plus random traffic against a queue model.
module tb_tm_ret_vc_allocator;
  localparam int NV    = 4;
  localparam int VAW   = 2;
  localparam int AW    = 4;
  localparam int NCRED = 32;
  localparam int ODEP  = 4;
  localparam int KW    = AW + VAW;
`ifdef TM_RET_VC_ALLOC_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           req_valid;
  logic [KW-1:0]  req_key;
  logic           noc_ready;
  logic           req_grant;
  logic [VAW-1:0] req_ret_vc;
  logic [NV-1:0]  reply_valid;
  logic [NV-1:0]  vc_busy;
  logic           ord_valid;
  logic [VAW-1:0] ord_vc;
  logic           ord_pop;
  logic           err;

  tm_ret_vc_allocator #(
    .NUM_VC(NV), .VC_ADDRESS_WIDTH(VAW), .ADDRESS_WIDTH(AW),
    .NUM_CREDITS(NCRED), .ORDER_DEPTH(ODEP)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_key(req_key),
    .noc_ready(noc_ready), .req_grant(req_grant), .req_ret_vc(req_ret_vc),
    .reply_valid(reply_valid), .vc_busy(vc_busy), .ord_valid(ord_valid),
    .ord_vc(ord_vc), .ord_pop(ord_pop), .err(err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: outstanding count per VC (bound == count>0), last key, issue-order queue.
  int             mcnt [NV];
  logic [KW-1:0]  mkey [NV];
  logic [VAW-1:0] mq [$];
  bit             merr;

  bit             exp_grant;
  int             exp_vc;
  bit             obs_grant;
  logic [VAW-1:0] obs_vc;

  function automatic logic [NV-1:0] exp_busy();
    logic [NV-1:0] b;
    for (int i = 0; i < NV; i++) b[i] = (mcnt[i] > 0);
    return b;
  endfunction

  function automatic logic [VAW-1:0] exp_ord_vc();
    return (mq.size() > 0) ? mq[0] : '0;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NV; i++) begin
      mcnt[i] = 0;
      mkey[i] = '0;
    end
    mq.delete();
    merr = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = 1'b0; req_key = '0; noc_ready = 1'b0; reply_valid = '0; ord_pop = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
  endtask

  // One cycle: drive inputs, predict and sample the handshake mid-cycle, advance the model at the edge.
  task automatic step(input bit v, input logic [KW-1:0] k, input bit rdy,
                      input logic [NV-1:0] rep, input bit pop);
    int  hit;
    int  cand;
    int  pre;
    bit  elig;
    bit  under;
    req_valid = v; req_key = k; noc_ready = rdy; reply_valid = rep; ord_pop = pop;
    #4;
    hit = -1;
    for (int i = 0; i < NV; i++) if (hit < 0 && mcnt[i] > 0 && mkey[i] == k) hit = i;
    cand = hit;
    if (hit >= 0) elig = (mcnt[hit] < NCRED);
    else begin
      for (int i = 0; i < NV; i++) if (cand < 0 && mcnt[i] == 0) cand = i;
      elig = (cand >= 0);
    end
    exp_grant = v && rdy && elig && (mq.size() < ODEP);
    exp_vc    = cand;
    obs_grant = req_grant;
    obs_vc    = req_ret_vc;
    pre       = mq.size();
    @(posedge clk);
    under = 1'b0;
    for (int i = 0; i < NV; i++) begin
      if (rep[i]) begin
        if (mcnt[i] == 0) under = 1'b1;
        else mcnt[i]--;
      end
    end
    if (exp_grant) begin
      mcnt[cand]++;
      mkey[cand] = k;
    end
    if (pop && pre > 0) void'(mq.pop_front());
    if (exp_grant) mq.push_back(VAW'(cand));
    if (CHK && (under || (pop && pre == 0) || (rep != '0 && pre == 0))) merr = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++; if (vc_busy !== 4'b0000) begin n_fail++; $display("FAIL reset_busy: got %b want 0000", vc_busy); end
    n_tests++; if (ord_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ord_valid: got %b want 0", ord_valid); end
    n_tests++; if (ord_vc !== 2'd0) begin n_fail++; $display("FAIL reset_ord_vc: got %0d want 0", ord_vc); end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
    n_tests++; if (req_grant !== 1'b0) begin n_fail++; $display("FAIL reset_grant: got %b want 0", req_grant); end
  endtask

  task automatic test_single_key();
    for (int c = 0; c < 3; c++) begin
      step(1'b1, 6'h05, 1'b1, 4'b0000, 1'b0);
      n_tests++; if (obs_grant !== 1'b1 || obs_vc !== 2'd0) begin
        n_fail++; $display("FAIL single_grant c%0d: got %b/vc%0d want 1/vc0", c, obs_grant, obs_vc);
      end
    end
    n_tests++; if (vc_busy !== 4'b0001) begin n_fail++; $display("FAIL single_busy: got %b want 0001", vc_busy); end
    for (int c = 0; c < 3; c++) begin
      n_tests++; if (ord_valid !== 1'b1 || ord_vc !== 2'd0) begin
        n_fail++; $display("FAIL single_order c%0d: got %b/vc%0d want 1/vc0", c, ord_valid, ord_vc);
      end
      step(1'b0, 6'h00, 1'b1, 4'b0001, 1'b1);
    end
    n_tests++; if (vc_busy !== 4'b0000 || ord_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_drain: got busy %b valid %b want 0000/0", vc_busy, ord_valid);
    end
  endtask

  task automatic test_no_free_vc();
    for (int k = 1; k <= 4; k++) begin
      step(1'b1, KW'(k), 1'b1, 4'b0000, 1'b1);
      n_tests++; if (obs_grant !== 1'b1 || obs_vc !== VAW'(k - 1)) begin
        n_fail++; $display("FAIL nofree_bind k%0d: got %b/vc%0d want 1/vc%0d", k, obs_grant, obs_vc, k - 1);
      end
    end
    n_tests++; if (vc_busy !== 4'b1111) begin n_fail++; $display("FAIL nofree_busy: got %b want 1111", vc_busy); end
    step(1'b1, 6'h05, 1'b1, 4'b0000, 1'b1);
    n_tests++; if (obs_grant !== 1'b0) begin n_fail++; $display("FAIL nofree_stall: got %b want 0", obs_grant); end
    step(1'b1, 6'h05, 1'b1, 4'b0001, 1'b1);
    n_tests++; if (obs_grant !== 1'b0) begin n_fail++; $display("FAIL nofree_reply_cycle: got %b want 0", obs_grant); end
    step(1'b1, 6'h05, 1'b1, 4'b0000, 1'b1);
    n_tests++; if (obs_grant !== 1'b1 || obs_vc !== 2'd0) begin
      n_fail++; $display("FAIL nofree_regrant: got %b/vc%0d want 1/vc0", obs_grant, obs_vc);
    end
    step(1'b0, 6'h00, 1'b1, 4'b1111, 1'b1);
    step(1'b0, 6'h00, 1'b1, 4'b0000, 1'b1);
    n_tests++; if (vc_busy !== exp_busy() || vc_busy !== 4'b0000) begin
      n_fail++; $display("FAIL nofree_drain: got %b want 0000", vc_busy);
    end
  endtask

  task automatic test_credits();
    int grants = 0;
    for (int c = 0; c < NCRED + 2; c++) begin
      step(1'b1, 6'h07, 1'b1, 4'b0000, 1'b1);
      if (obs_grant === 1'b1) grants++;
      n_tests++; if (obs_grant !== exp_grant) begin
        n_fail++; $display("FAIL credit_grant c%0d: got %b want %b", c, obs_grant, exp_grant);
      end
    end
    n_tests++; if (grants != NCRED) begin n_fail++; $display("FAIL credit_total: got %0d want %0d", grants, NCRED); end
    step(1'b1, 6'h07, 1'b1, 4'b0001, 1'b1);
    n_tests++; if (obs_grant !== 1'b0) begin n_fail++; $display("FAIL credit_reply_cycle: got %b want 0", obs_grant); end
    step(1'b1, 6'h07, 1'b1, 4'b0000, 1'b1);
    n_tests++; if (obs_grant !== 1'b1) begin n_fail++; $display("FAIL credit_one_more: got %b want 1", obs_grant); end
    step(1'b1, 6'h07, 1'b1, 4'b0000, 1'b1);
    n_tests++; if (obs_grant !== 1'b0) begin n_fail++; $display("FAIL credit_restall: got %b want 0", obs_grant); end
    repeat (NCRED) step(1'b0, 6'h00, 1'b1, 4'b0001, 1'b1);
    n_tests++; if (vc_busy !== 4'b0000) begin n_fail++; $display("FAIL credit_drain: got %b want 0000", vc_busy); end
  endtask

  task automatic test_same_cycle();
    step(1'b1, 6'h09, 1'b1, 4'b0000, 1'b0);
    step(1'b1, 6'h09, 1'b1, 4'b0001, 1'b0);
    n_tests++; if (obs_grant !== 1'b1 || obs_vc !== 2'd0) begin
      n_fail++; $display("FAIL same_grant: got %b/vc%0d want 1/vc0", obs_grant, obs_vc);
    end
    n_tests++; if (vc_busy !== 4'b0001) begin n_fail++; $display("FAIL same_busy: got %b want 0001", vc_busy); end
    step(1'b0, 6'h00, 1'b1, 4'b0001, 1'b1);
    n_tests++; if (vc_busy !== 4'b0000) begin n_fail++; $display("FAIL same_release: got %b want 0000", vc_busy); end
    step(1'b0, 6'h00, 1'b1, 4'b0000, 1'b1);
    n_tests++; if (ord_valid !== 1'b0) begin n_fail++; $display("FAIL same_fifo_empty: got %b want 0", ord_valid); end
  endtask

  task automatic test_fifo_full();
    logic [VAW-1:0] want;
    for (int k = 1; k <= 4; k++) step(1'b1, KW'(k), 1'b1, 4'b0000, 1'b0);
    step(1'b1, 6'h01, 1'b1, 4'b0000, 1'b0);
    n_tests++; if (obs_grant !== 1'b0) begin n_fail++; $display("FAIL full_block: got %b want 0", obs_grant); end
    step(1'b1, 6'h01, 1'b1, 4'b0000, 1'b1);
    n_tests++; if (obs_grant !== 1'b0) begin n_fail++; $display("FAIL full_pop_cycle: got %b want 0", obs_grant); end
    step(1'b1, 6'h01, 1'b1, 4'b0000, 1'b0);
    n_tests++; if (obs_grant !== 1'b1 || obs_vc !== 2'd0) begin
      n_fail++; $display("FAIL full_resume: got %b/vc%0d want 1/vc0", obs_grant, obs_vc);
    end
    for (int c = 0; c < 4; c++) begin
      want = (c == 3) ? 2'd0 : VAW'(c + 1);
      n_tests++; if (ord_valid !== 1'b1 || ord_vc !== want || ord_vc !== exp_ord_vc()) begin
        n_fail++; $display("FAIL full_order c%0d: got %b/vc%0d want 1/vc%0d", c, ord_valid, ord_vc, want);
      end
      step(1'b0, 6'h00, 1'b1, 4'b0000, 1'b1);
    end
    step(1'b0, 6'h00, 1'b1, 4'b1111, 1'b0);
    step(1'b0, 6'h00, 1'b1, 4'b0001, 1'b0);
    n_tests++; if (vc_busy !== 4'b0000) begin n_fail++; $display("FAIL full_drain: got %b want 0000", vc_busy); end
  endtask

  task automatic test_underflow();
    do_reset();
    step(1'b0, 6'h00, 1'b1, 4'b0100, 1'b0);
    n_tests++; if (vc_busy !== 4'b0000) begin n_fail++; $display("FAIL under_busy: got %b want 0000", vc_busy); end
    n_tests++; if (err !== CHK) begin n_fail++; $display("FAIL under_err: got %b want %b", err, CHK); end
    step(1'b0, 6'h00, 1'b1, 4'b0100, 1'b0);
    step(1'b1, 6'h3c, 1'b1, 4'b0000, 1'b0);
    n_tests++; if (obs_grant !== 1'b1 || obs_vc !== 2'd0) begin
      n_fail++; $display("FAIL under_sat_grant: got %b/vc%0d want 1/vc0", obs_grant, obs_vc);
    end
    req_valid = 1'b1; req_key = 6'h11; noc_ready = 1'b1;
    rst = 1'b1;
    #1;
    n_tests++; if (vc_busy !== 4'b0000 || ord_valid !== 1'b0 || err !== 1'b0 || req_grant !== 1'b0) begin
      n_fail++; $display("FAIL midreset: got busy %b valid %b err %b grant %b want 0000/0/0/0",
                         vc_busy, ord_valid, err, req_grant);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
    step(1'b0, 6'h00, 1'b1, 4'b0001, 1'b0);
    n_tests++; if (vc_busy !== 4'b0000 || err !== CHK) begin
      n_fail++; $display("FAIL post_reset_reply: got busy %b err %b want 0000/%b", vc_busy, err, CHK);
    end
    do_reset();
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_clear: got %b want 0", err); end
  endtask

  task automatic test_random();
    bit            v;
    bit            rdy;
    bit            pop;
    logic [KW-1:0] k;
    logic [NV-1:0] rep;
    for (int c = 0; c < 600; c++) begin
      v   = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 4) != 0);
      pop = ($urandom_range(0, 2) != 0);
      k   = KW'($urandom_range(0, 5));
      rep = NV'($urandom) & (($urandom_range(0, 9) == 0) ? 4'b1111 : exp_busy());
      step(v, k, rdy, rep, pop);
      n_tests++; if (obs_grant !== exp_grant) begin
        n_fail++; $display("FAIL rand_grant c%0d: got %b want %b", c, obs_grant, exp_grant);
      end
      if (exp_grant) begin
        n_tests++; if (obs_vc !== VAW'(exp_vc)) begin
          n_fail++; $display("FAIL rand_vc c%0d: got %0d want %0d", c, obs_vc, exp_vc);
        end
      end
      n_tests++; if (vc_busy !== exp_busy()) begin
        n_fail++; $display("FAIL rand_busy c%0d: got %b want %b", c, vc_busy, exp_busy());
      end
      n_tests++; if (ord_valid !== (mq.size() > 0) || ord_vc !== exp_ord_vc()) begin
        n_fail++; $display("FAIL rand_order c%0d: got %b/vc%0d want %b/vc%0d",
                           c, ord_valid, ord_vc, (mq.size() > 0), exp_ord_vc());
      end
      n_tests++; if (err !== merr) begin
        n_fail++; $display("FAIL rand_err c%0d: got %b want %b", c, err, merr);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_key = '0; noc_ready = 1'b0; reply_valid = '0; ord_pop = 1'b0;
    model_clear();
    test_reset();
    test_single_key();
    test_no_free_vc();
    test_credits();
    test_same_cycle();
    test_fifo_full();
    test_underflow();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
